// File: rtl/hazard_pkg.sv
// Shared types and helpers for the forwarding/hazard unit.
// Tracker entries carry a fixed-width dst; callers zero-extend narrower indices.
package hazard_pkg;

  localparam int unsigned MAX_REG_W = 8;
  localparam int unsigned SEL_RF    = 0;

  typedef struct packed {
    logic                 valid;
    logic [MAX_REG_W-1:0] dst;
    logic                 is_load;
  } trk_entry_t;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fwd_src_match.sv
// Youngest-match priority encoder for one source operand over the write tracker.
module fwd_src_match
  import hazard_pkg::*;
#(
  parameter int unsigned DEPTH = 3,
  parameter int unsigned SEL_W = 2
) (
  input  logic                   used,
  input  logic [MAX_REG_W-1:0]   src,
  input  trk_entry_t [DEPTH-1:0] trk,
  output logic                   hit,
  output logic [SEL_W-1:0]       stage,
  output logic                   is_load
);

  // Scan oldest to youngest so the lowest matching stage is the one left standing.
  always_comb begin
    hit     = 1'b0;
    stage   = '0;
    is_load = 1'b0;
    for (int unsigned j = DEPTH; j > 0; j--) begin
      if (used && trk[j-1].valid && (trk[j-1].dst == src)) begin
        hit     = 1'b1;
        stage   = SEL_W'(j - 1);
        is_load = trk[j-1].is_load;
      end
    end
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding tap selection and load-use / no-forwarding stall generation,
// driven by a shift register of in-flight register writes.
module fwd_hazard_unit
  import hazard_pkg::*;
#(
  parameter int unsigned REG_W    = 4,
  parameter int unsigned NUM_SRC  = 3,
  parameter int unsigned DEPTH    = 3,
  parameter int unsigned LOAD_LAT = 1,
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned SEL_W    = clog2(DEPTH + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     fwd_en,
  input  logic                     issue_valid,
  input  logic                     id_wb_en,
  input  logic [REG_W-1:0]         id_dst,
  input  logic                     id_is_load,
  input  logic [NUM_SRC*REG_W-1:0] id_src,
  input  logic [NUM_SRC-1:0]       id_src_used,
  input  logic                     flush,
  output logic                     stall,
  output logic [NUM_SRC*SEL_W-1:0] ex_sel,
  output logic [CNT_W-1:0]         stall_cnt
);

  trk_entry_t [DEPTH-1:0]   trk;
  logic [NUM_SRC-1:0]       hit;
  logic [NUM_SRC-1:0]       src_ld;
  logic [NUM_SRC-1:0]       haz;
  logic [SEL_W-1:0]         stage [NUM_SRC];
  logic [NUM_SRC*SEL_W-1:0] next_sel;
  logic                     issue_ok;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_match
    fwd_src_match #(
      .DEPTH (DEPTH),
      .SEL_W (SEL_W)
    ) u_match (
      .used    (id_src_used[i]),
      .src     (MAX_REG_W'(id_src[i*REG_W +: REG_W])),
      .trk     (trk),
      .hit     (hit[i]),
      .stage   (stage[i]),
      .is_load (src_ld[i])
    );
  end

  always_comb begin
    haz      = '0;
    next_sel = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      next_sel[i*SEL_W +: SEL_W] = SEL_W'(SEL_RF);
      if (hit[i]) begin
        if (!fwd_en)
          haz[i] = 1'b1;
        else if (src_ld[i] && (32'(stage[i]) < LOAD_LAT))
          haz[i] = 1'b1;
        else
          next_sel[i*SEL_W +: SEL_W] = stage[i] + SEL_W'(1);
      end
    end
  end

  assign stall    = issue_valid & ~flush & (|haz);
  assign issue_ok = issue_valid & ~stall & ~flush;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      trk <= '0;
    end else begin
      trk[0] <= {issue_ok & id_wb_en, MAX_REG_W'(id_dst), id_is_load};
      for (int unsigned k = 1; k < DEPTH; k++) trk[k] <= trk[k-1];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_sel    <= '0;
      stall_cnt <= '0;
    end else begin
      ex_sel <= issue_ok ? next_sel : '0;
      if (stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule
